fd_pipe_stage: RTL and testbench
================================

Name: fd_pipe_stage

Overview:
Parametrised fetch-to-decode pipeline register. It replaces the plain stall-gated IF/ID flop with an elastic stage that uses a valid/ready handshake and a one-entry skid buffer. It adds flush, with bubble (NOP) insertion, and asynchronous reset. It sits between the fetch unit (PC and instruction memory) and the decode/register-file stage. Full throughput is one instruction per cycle.

Parameters:
XLEN, 32, width of instruction, PC and PC+4 fields
NOP_INSTR, 32'h0000_0013, instruction driven on InstrD when the stage holds no valid entry (addi x0,x0,0)
RESET_PC, 32'h0000_0000, value of PCD and inc_PCD after reset and after flush

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  kill all held and incoming entries this cycle (branch/jump redirect)
in_valid  in  1  fetch presents a valid instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
InstrF  in  XLEN  fetched instruction
PCF  in  XLEN  fetch PC
inc_PCF  in  XLEN  fetch PC+4
out_valid  out  1  InstrD/PCD/inc_PCD hold a valid entry
out_ready  in  1  decode accepts (replaces the inverted Stall)
InstrD  out  XLEN  instruction to decode
PCD  out  XLEN  PC to decode
inc_PCD  out  XLEN  PC+4 to decode

Behaviour:
- Reset (rst_n=0, asynchronous):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - InstrD=NOP_INSTR; PCD=inc_PCD=RESET_PC.
  - Skid payload is don't-care.
  - Reset mid-transfer drops all entries.
- Events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: an instruction accepted at edge N appears on the outputs after edge N. This gives 1 cycle of latency with no bubble.
- Main register update, when out_ready | !main_valid:
  - if skid_valid: load the skid payload; skid_valid<=0.
  - else if in_fire: load the input; main_valid<=1.
  - else: main_valid<=0 and the payload holds its last value. Output muxing forces InstrD=NOP_INSTR whenever out_valid=0.
- Skid update: when in_fire & main_valid & !out_ready, the input goes into skid and skid_valid<=1.
- Full condition: when skid_valid=1, in_ready=0. Fetch must hold its inputs stable until in_ready returns.
- in_ready is registered and changes only on a clock edge. There is no combinational path from out_ready to in_ready.
- Flush has priority over every other event. In the cycle flush=1:
  - main_valid<=0 and skid_valid<=0.
  - the in_fire entry is discarded.
  - PCD and inc_PCD <= RESET_PC.
  - next cycle: out_valid=0, InstrD=NOP_INSTR, in_ready=1.
- Flush together with out_fire: the downstream transfer of the current entry completes. Only the stored state is cleared.
- Ordering is strictly FIFO: skid content always drains before new input.
- Data is never dropped or duplicated except by flush or reset.
- Maximum occupancy is 2 entries.

Optional Feature:
Macro FD_PIPE_PERF_EN.
- When defined, the block adds three output ports:
  - stall_cnt [31:0]: increments each cycle with in_valid & !in_ready.
  - bubble_cnt [31:0]: increments each cycle with !out_valid & out_ready.
  - flush_cnt [31:0]: increments on each flush.
- All three counters are reset to 0 by rst_n and saturate at 32'hFFFF_FFFF.
- When not defined, the ports and logic are absent and the datapath behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef fd_payload_t, a packed struct {instr, pc, inc_pc}, each XLEN bits.
  - localparam NOP_RV32I = 32'h0000_0013.
  - fd_nop_payload(), which returns NOP with RESET_PC.
- One natural sub-module, skid_buf: a generic one-entry valid/ready skid buffer over a payload type, with a flush input. fd_pipe_stage instantiates it and adds the NOP/reset-PC output forcing and the perf counters.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 with PCF=0,4,8,…,28 over 8 cycles. Required: PCD sequence 0..28 one cycle later, out_valid=1 continuously, in_ready never 0.
- Backpressure: hold out_ready=0 for 3 cycles while streaming from PCF=0x100. Required: PCD holds 0x100; skid captures 0x104; in_ready=0 from the next edge. On release, PCD=0x104 then 0x108 in order, with no loss or duplication.
- Flush while full: main=0x200 and skid=0x204, assert flush with in_valid=1 and PCF=0x208. Required next cycle: out_valid=0, InstrD=0x0000_0013, PCD=RESET_PC, in_ready=1. Entries 0x200, 0x204 and 0x208 never reach decode.
- Asynchronous reset: drop rst_n mid-cycle with both entries valid. Required: out_valid=0 and InstrD=NOP_INSTR immediately, before any clock edge. After release, the first accepted PCF=0x40 appears after one edge.
- Idle input: in_valid=0 with out_ready=1. Required: out_valid=0 and InstrD=0x0000_0013 every cycle.
- Counters (FD_PIPE_PERF_EN defined): 3 stall cycles, 2 flushes and 4 bubble cycles. Required: stall_cnt=3, flush_cnt=2, bubble_cnt=4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared payload type, constants and helpers for the fetch/decode pipeline registers.
package pipe_pkg;

  localparam int PIPE_XLEN = 32;
  localparam logic [PIPE_XLEN-1:0] NOP_RV32I = 32'h0000_0013;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] instr;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] inc_pc;
  } fd_payload_t;

  // Payload an empty decode slot presents: addi x0,x0,0 at the restart PC.
  function automatic fd_payload_t fd_nop_payload(
    input logic [PIPE_XLEN-1:0] reset_pc,
    input logic [PIPE_XLEN-1:0] nop = NOP_RV32I
  );
    fd_payload_t p;
    p.instr  = nop;
    p.pc     = reset_pc;
    p.inc_pc = reset_pc;
    return p;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != CNT_MAX)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic one-entry valid/ready skid buffer with flush; in_ready is a pure flop output.
module skid_buf #(
  parameter type T = logic [31:0],
  parameter T RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic main_valid;
  logic skid_valid;
  T     main_data;
  T     skid_data;
  logic in_fire;

  assign in_fire   = in_valid & in_ready;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Skid always drains into main before new input, keeping strict FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_data  <= RESET_VAL;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else begin
      if (out_ready || !main_valid) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end
      if (in_fire && main_valid && !out_ready) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fd_pipe_stage.sv
// Elastic fetch-to-decode register: skid-buffered handshake, flush, NOP bubble insertion.
// Define FD_PIPE_PERF_EN to add saturating stall/bubble/flush counters; XLEN must equal PIPE_XLEN.
module fd_pipe_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = PIPE_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_RV32I,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] inc_PCF,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] inc_PCD
`ifdef FD_PIPE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam fd_payload_t RESET_PAYLOAD = fd_nop_payload(RESET_PC, NOP_INSTR);

  fd_payload_t in_payload;
  fd_payload_t out_payload;
  logic        main_valid;

  always_comb begin
    in_payload        = RESET_PAYLOAD;
    in_payload.instr  = InstrF;
    in_payload.pc     = PCF;
    in_payload.inc_pc = inc_PCF;
  end

  skid_buf #(
    .T         (fd_payload_t),
    .RESET_VAL (RESET_PAYLOAD)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (main_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  // An empty slot shows a NOP so decode never executes a stale instruction.
  assign out_valid = main_valid;
  assign InstrD    = main_valid ? out_payload.instr : NOP_INSTR;
  assign PCD       = out_payload.pc;
  assign inc_PCD   = out_payload.inc_pc;

`ifdef FD_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, in_valid & ~in_ready);
      bubble_cnt <= sat_inc(bubble_cnt, ~main_valid & out_ready);
      flush_cnt  <= sat_inc(flush_cnt, flush);
    end
  end
`endif

endmodule

// File: tb/tb_fd_pipe_stage.sv
// Self-checking bench for fd_pipe_stage against a FIFO-occupancy reference model.
`timescale 1ns/1ps
module tb_fd_pipe_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] InstrF = '0, PCF = '0, inc_PCF = '0;
  logic [31:0] InstrD, PCD, inc_PCD;
`ifdef FD_PIPE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0] m_stall = '0, m_bubble = '0, m_flush = '0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] inc;
  } entry_t;

  entry_t      q[$];
  logic [31:0] shown_pc = RST_PC;
  logic [31:0] shown_inc = RST_PC;
  int vectors = 0;
  int miscompares = 0;

  fd_pipe_stage #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .inc_PCF   (inc_PCF),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .inc_PCD   (inc_PCD)
`ifdef FD_PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most two entries.
  task automatic model_reset();
    q.delete();
    shown_pc  = RST_PC;
    shown_inc = RST_PC;
`ifdef FD_PIPE_PERF_EN
    m_stall = '0; m_bubble = '0; m_flush = '0;
`endif
  endtask

  task automatic model_edge();
    bit accept, deliver;
    entry_t e;
    accept  = in_valid && (q.size() < 2);
    deliver = out_ready && (q.size() > 0);
`ifdef FD_PIPE_PERF_EN
    if (in_valid && q.size() >= 2) m_stall++;
    if (q.size() == 0 && out_ready) m_bubble++;
    if (flush) m_flush++;
`endif
    if (flush) begin
      q.delete();
      shown_pc  = RST_PC;
      shown_inc = RST_PC;
    end else begin
      if (deliver) void'(q.pop_front());
      if (accept) begin
        e.instr = InstrF; e.pc = PCF; e.inc = inc_PCF;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        shown_pc  = q[0].pc;
        shown_inc = q[0].inc;
      end
    end
  endtask

  function automatic logic [97:0] expected();
    if (q.size() > 0) return {1'b1, q.size() < 2, q[0].instr, q[0].pc, q[0].inc};
    return {1'b0, 1'b1, NOP, shown_pc, shown_inc};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    PCF      = pc;
    inc_PCF  = pc + 32'd4;
    InstrF   = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== {1'b0, 1'b1, NOP, RST_PC, RST_PC}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected %h",
               {out_valid, in_ready, InstrD, PCD, inc_PCD}, {1'b0, 1'b1, NOP, RST_PC, RST_PC});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4));
      tick();
      vectors++;
      if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected() || PCD !== 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL stream[%0d]: got %h expected %h (pc %h)",
                 i, {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected(), 32'(i * 4));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs[6]  = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108};
    logic        ors[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] epcd[6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h108};
    logic        erdy[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      out_ready = ors[i];
      if (i == 0 || pcs[i] != pcs[i-1]) drive(1'b1, pcs[i]);
      tick();
      vectors++;
      if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected() ||
          PCD !== epcd[i] || in_ready !== erdy[i]) begin
        miscompares++;
        $display("[TB] FAIL backpressure[%0d]: got %h expected %h (pcd %h rdy %b)",
                 i, {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected(), epcd[i], erdy[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h200); tick();
    drive(1'b1, 32'h204); tick();
    drive(1'b1, 32'h208); flush = 1'b1; tick();
    flush = 1'b0;
    vectors++;
    if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== {1'b0, 1'b1, NOP, RST_PC, RST_PC}) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got %h expected %h",
               {out_valid, in_ready, InstrD, PCD, inc_PCD}, {1'b0, 1'b1, NOP, RST_PC, RST_PC});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected() || out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_after[%0d]: got %h expected %h",
                 i, {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected());
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h300); tick();
    drive(1'b1, 32'h304); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== {1'b0, 1'b1, NOP, RST_PC, RST_PC}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected %h",
               {out_valid, in_ready, InstrD, PCD, inc_PCD}, {1'b0, 1'b1, NOP, RST_PC, RST_PC});
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h40); out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected() || PCD !== 32'h40 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got %h expected %h",
               {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_idle();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected() ||
          out_valid !== 1'b0 || InstrD !== NOP) begin
        miscompares++;
        $display("[TB] FAIL idle[%0d]: got %h expected %h",
                 i, {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      // A refused instruction stays presented until the stage has room.
      if (!(in_valid && q.size() >= 2))
        drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      tick();
      vectors++;
      if ({out_valid, in_ready, InstrD, PCD, inc_PCD} !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got %h expected %h",
                 i, {out_valid, in_ready, InstrD, PCD, inc_PCD}, expected());
      end
    end
    flush = 1'b0; in_valid = 1'b0;
`ifdef FD_PIPE_PERF_EN
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {m_stall, m_bubble, m_flush}) begin
      miscompares++;
      $display("[TB] FAIL random_counters: got %h expected %h",
               {stall_cnt, bubble_cnt, flush_cnt}, {m_stall, m_bubble, m_flush});
    end
`endif
  endtask

`ifdef FD_PIPE_PERF_EN
  task automatic test_counters();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 32'h0); tick();
    drive(1'b1, 32'h4); tick();
    drive(1'b1, 32'h8);
    repeat (3) tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    out_ready = 1'b1; tick();
    flush = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {32'd3, 32'd4, 32'd2} ||
        {stall_cnt, bubble_cnt, flush_cnt} !== {m_stall, m_bubble, m_flush}) begin
      miscompares++;
      $display("[TB] FAIL counters: got stall %0d bubble %0d flush %0d expected 3 4 2",
               stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_async_reset();
    test_idle();
    test_random();
`ifdef FD_PIPE_PERF_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
